// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates one shared single-port memory between an instruction-fetch port
// (read-only) and a load/store data port.
//
// Ports
//   clk, rstn                       clock, asynchronous active-low reset
//   i_req, i_addr                   fetch request and word address
//   i_rdata, i_done                 fetch read data, one-cycle completion pulse
//   d_req, d_we, d_be, d_addr,      load/store request and fields
//   d_wdata
//   d_rdata, d_done                 load/store read data, one-cycle completion pulse
//   m_req, m_we, m_be, m_addr,      memory request towards the shared memory
//   m_wdata
//   m_rdata, m_ack                  memory read data and acknowledge
//   err                             one-cycle pulse, coincident with x_done, on a timed-out access
//   dbg_state                       current FSM state, for observation only
//
// Handshake: a requester raises x_req with its fields and holds all of them
// stable until it sees its x_done pulse. The arbiter samples the fields only
// at grant. Towards memory, m_req and its fields stay stable until m_ack is
// sampled high (or the access times out); m_ack is ignored whenever m_req is low.

module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rstn,
  // instruction-fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  // load/store port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  // shared memory
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  // status
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  // Timeout fires in the BUSY cycle whose increment would make wait_cnt reach
  // TIMEOUT, so m_req is high for exactly TIMEOUT cycles.
  localparam logic [7:0]    WAIT_LAST  = 8'(TIMEOUT - 1);

  state_e         state_q;
  logic [SW-1:0]  starve_q;
  logic [SW-1:0]  starve_d;
  logic [7:0]     wait_q;
  logic           m_req_q;
  logic           m_we_q;
  logic [3:0]     m_be_q;
  logic [31:0]    m_addr_q;
  logic [31:0]    m_wdata_q;
  logic [31:0]    i_rdata_q;
  logic [31:0]    d_rdata_q;
  logic           i_done_q;
  logic           d_done_q;
  logic           err_q;
  logic           fetch_win;

  // Data has priority; fetch wins only when data has starved it STARVE_MAX times.
  always_comb begin
    fetch_win = i_req && (!d_req || (starve_q == STARVE_LIM));
    starve_d  = starve_q;
    if (fetch_win) begin
      starve_d = '0;
    end else if (i_req) begin
      starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + 1'b1;
    end else begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      wait_q    <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // completion and error flags are single-cycle pulses
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            wait_q   <= '0;
            m_req_q  <= 1'b1;
            starve_q <= starve_d;
            if (fetch_win) begin
              state_q   <= BUSY_I;
              m_we_q    <= 1'b0;
              m_be_q    <= 4'hF;
              m_addr_q  <= i_addr;
              m_wdata_q <= '0;
            end else begin
              state_q   <= BUSY_D;
              m_we_q    <= d_we;
              m_be_q    <= d_be;
              m_addr_q  <= d_addr;
              m_wdata_q <= d_wdata;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          // an ack in the timeout cycle still completes normally
          if (m_ack) begin
            m_req_q <= 1'b0;
            state_q <= DONE;
            if (state_q == BUSY_I) begin
              i_rdata_q <= m_rdata;
              i_done_q  <= 1'b1;
            end else begin
              d_rdata_q <= m_rdata;
              d_done_q  <= 1'b1;
            end
          end else if (wait_q == WAIT_LAST) begin
            m_req_q <= 1'b0;
            state_q <= DONE;
            wait_q  <= wait_q + 8'd1;
            err_q   <= 1'b1;
            if (state_q == BUSY_I) begin
              i_rdata_q <= '0;
              i_done_q  <= 1'b1;
            end else begin
              d_rdata_q <= '0;
              d_done_q  <= 1'b1;
            end
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        DONE: begin
          // never grants here, so a req still high during done is not re-served
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_be      = m_be_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
